rr_priority_encoder: RTL and testbench
======================================

Name: rr_priority_encoder

Overview:
- Encoding counterpart of the team's 2-to-4 address decoder: collapses an N-bit request vector into one granted binary index plus a matching one-hot vector.
- Round-robin priority, with a registered output slice using a valid/ready handshake.
- Sits between reservation-station entry request lines and the issue/select logic. The granted index feeds the downstream decoders and read muxes.

Parameters:
- N, default 4: number of request lines. Legal range is N ≥ 2; values other than powers of two are legal.
- W, default $clog2(N): width of the binary index. Derived; must not be overridden.

Ports:
- clk, input, 1: rising-edge clock.
- reset_n, input, 1: synchronous reset, active-low.
- req, input, N: request vector; bit i high means requester i wants a grant. No handshake on this input; it is sampled every cycle.
- flush, input, 1: synchronous discard of any pending grant.
- grant_ready, input, 1: consumer accepts the current grant.
- grant_valid, output, 1: grant_idx and grant_onehot are meaningful.
- grant_idx, output, W: binary index of the granted requester.
- grant_onehot, output, N: one-hot form of grant_idx; all zeros when grant_valid is 0.

Behaviour:
- Reset: when reset_n is sampled low at a clock edge, grant_valid, grant_idx, grant_onehot and the internal pointer ptr (W bits) all become 0. Reset has priority over every other input, including mid-handshake.
- Handshake fire = grant_valid & grant_ready.
- Effective base pointer: base = fire ? (grant_idx+1 mod N) : ptr.
- Pick: scan req starting at bit base, ascending and wrapping from N-1 to 0. The first set bit is the pick. any = |req.
- Load enable: load = !grant_valid | grant_ready.
- Per-edge update, evaluated in priority order:
  1. If reset_n is low, apply the reset values above.
  2. Else if flush: grant_valid ← 0 and grant_onehot ← 0. grant_idx holds. ptr ← base, so a grant that fires in the flush cycle still advances the pointer.
  3. Else if load: grant_valid ← any; grant_idx ← pick (or 0 if !any); grant_onehot ← 1<<pick (or 0); ptr ← base.
  4. Else (stalled, i.e. valid & !ready): all outputs and ptr hold.
- Latency: one cycle from req to grant_valid when the slice is empty or draining. Back-to-back grants sustain one per cycle while grant_ready stays high.
- Stability: while grant_valid & !grant_ready, the outputs stay frozen. This holds even if the granted req bit drops or higher-priority bits rise. There is no retraction.
- Fairness: after requester k is accepted, k has the lowest priority for the next pick. With all N requesting continuously and ready held high, the grant order is 0,1,…,N-1,0,…
- Single requester re-asserting after its own accept: it is re-granted (base wraps around to it).
- Wrap-around: grant_idx = N-1 accepted → base = 0. Must be correct when N is not a power of two; for example, with N=6 it must never produce 6 or 7.
- Stall: ptr does not advance while stalled.
- Simultaneous fire and new req in one cycle: the new grant loads in that same edge, using base from the fire.
- req = 0 with load: grant_valid ← 0; ptr still updates to base.
- Invariant for assertions: grant_valid → grant_onehot == 1<<grant_idx and grant_idx < N. !grant_valid → grant_onehot == 0.

Decomposition:
- Shared package enc_pkg holds:
  - default N constant ENC_DEFAULT_N = 4;
  - function onehot_to_bin, which returns the index of the single set bit, for bench checks and reuse;
  - function idx_wrap_inc, computing (i+1) mod N.
- Sub-module rr_pick_comb: purely combinational, taking (req, base) and returning (any, pick), rotate-then-priority-encode.
- rr_priority_encoder instantiates rr_pick_comb and owns the output register slice and ptr.

Test Plan (N=4 unless noted):
- Reset mid-stall: hold grant_valid=1 with grant_idx=2 and ready low, then pulse reset_n low for one cycle → next cycle grant_valid=0, idx=0, onehot=0000. The first grant after reset with req=1111 is idx 0.
- Round-robin sweep: req=1111 held, ready=1 → idx sequence 0,1,2,3,0 on consecutive cycles, with grant_valid high every cycle from cycle 1.
- Stall stability: req=0100 yields grant idx 2. Hold ready=0 for 3 cycles while req changes to 0001 → idx stays 2 and onehot 0100 for all 3 cycles. Raise ready → next cycle idx 0.
- Priority after accept: accept idx 1, then req=0011 → next grant idx 0 (1 is now lowest). Accept, then req=0011 again → idx 1.
- Flush: grant idx 3 pending with ready=0, assert flush → next cycle grant_valid=0 and ptr unchanged. Then req=1001 → grant idx 0.
- Non-power-of-two (N=6, W=3): accept idx 5, then req=100001 → idx 0. With req=000000 and load enabled → grant_valid=0. grant_idx is never ≥ 6 across a random 1000-cycle run checked against the reference model.

Source files
------------

// File: rtl/enc_pkg.sv
// Shared constants and index helpers for the round-robin encoder and its users.
package enc_pkg;

  localparam int ENC_DEFAULT_N = 4;

  // Index of the single set bit; returns the highest set bit if several are set.
  function automatic int onehot_to_bin(input logic [31:0] v);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if (v[i]) r = i;
    end
    return r;
  endfunction

  function automatic int idx_wrap_inc(input int i, input int n);
    return (i + 1 >= n) ? 0 : i + 1;
  endfunction

endpackage

// File: rtl/rr_pick_comb.sv
// Combinational round-robin pick: first set bit of req scanning upward from base, wrapping.
// Zero latency; no flow control.
module rr_pick_comb #(
  parameter int N = 4,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] base,
  output logic         any,
  output logic [W-1:0] pick
);

  localparam logic [W:0] N_EXT = (W+1)'(N);

  logic [N-1:0] rot;
  logic [W-1:0] off;
  logic [W:0]   sum;
  logic         found;

  always_comb begin
    rot   = N'({req, req} >> base);
    off   = '0;
    found = 1'b0;
    for (int j = 0; j < N; j++) begin
      if (!found && rot[j]) begin
        found = 1'b1;
        off   = W'(j);
      end
    end
    // base + off stays below 2N, so one conditional subtract keeps the pick inside 0..N-1.
    sum = {1'b0, base} + {1'b0, off};
    if (sum >= N_EXT) sum = sum - N_EXT;
    pick = sum[W-1:0];
    any  = |req;
  end

endmodule

// File: rtl/rr_priority_encoder.sv
// Round-robin priority encoder with a registered valid/ready output slice.
// One cycle req-to-grant; a stalled grant is held frozen until accepted or flushed.
module rr_priority_encoder
  import enc_pkg::*;
#(
  parameter int N = ENC_DEFAULT_N,
  parameter int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [N-1:0] req,
  input  logic         flush,
  input  logic         grant_ready,
  output logic         grant_valid,
  output logic [W-1:0] grant_idx,
  output logic [N-1:0] grant_onehot
);

  localparam logic [N-1:0] ONE = N'(1);

  logic [W-1:0] ptr;
  logic [W-1:0] base;
  logic [W-1:0] pick;
  logic         any;
  logic         fire;
  logic         load;

  // An accepted grant pushes its own index to lowest priority for the pick made this edge.
  always_comb begin
    fire = grant_valid & grant_ready;
    load = !grant_valid | grant_ready;
    base = fire ? W'(idx_wrap_inc(int'(grant_idx), N)) : ptr;
  end

  rr_pick_comb #(.N(N), .W(W)) u_pick (
    .req  (req),
    .base (base),
    .any  (any),
    .pick (pick)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      grant_valid  <= 1'b0;
      grant_idx    <= '0;
      grant_onehot <= '0;
      ptr          <= '0;
    end else if (flush) begin
      grant_valid  <= 1'b0;
      grant_onehot <= '0;
      ptr          <= base;
    end else if (load) begin
      grant_valid  <= any;
      grant_idx    <= any ? pick : '0;
      grant_onehot <= any ? (ONE << pick) : '0;
      ptr          <= base;
    end
  end

endmodule

// File: tb/tb_rr_priority_encoder.sv
// Bench for rr_priority_encoder at N=4 and N=6 against a per-cycle reference model.
module tb_rr_priority_encoder;
  import enc_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req4;
  logic       rdy4, flush4;
  logic       vld4;
  logic [1:0] idx4;
  logic [3:0] oh4;
  logic [5:0] req6;
  logic       rdy6, flush6;
  logic       vld6;
  logic [2:0] idx6;
  logic [5:0] oh6;

  int tests = 0;
  int fails = 0;
  bit checking = 1'b0;

  typedef struct packed {
    logic v;
    int   idx;
    int   ptr;
  } ms_t;

  ms_t m4 = '0;
  ms_t m6 = '0;

  always #5 clk = ~clk;

  rr_priority_encoder #(.N(4)) u4 (
    .clk(clk), .reset_n(rst_n), .req(req4), .flush(flush4), .grant_ready(rdy4),
    .grant_valid(vld4), .grant_idx(idx4), .grant_onehot(oh4)
  );

  rr_priority_encoder #(.N(6)) u6 (
    .clk(clk), .reset_n(rst_n), .req(req6), .flush(flush6), .grant_ready(rdy6),
    .grant_valid(vld6), .grant_idx(idx6), .grant_onehot(oh6)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference behaviour: state is (valid, idx, ptr) as plain integers.
  function automatic ms_t step(input ms_t s, input int n, input bit rn, input bit fl,
                               input bit rdy, input logic [7:0] rq);
    ms_t r;
    int  base, pk, j;
    if (!rn) return '0;
    r    = s;
    base = (s.v && rdy) ? (s.idx + 1) % n : s.ptr;
    pk   = -1;
    for (int k = 0; k < n; k++) begin
      j = (base + k) % n;
      if (pk < 0 && rq[j]) pk = j;
    end
    if (fl) begin
      r.v   = 1'b0;
      r.ptr = base;
    end else if (!s.v || rdy) begin
      r.v   = (pk >= 0);
      r.idx = (pk >= 0) ? pk : s.idx * 0;
      r.ptr = base;
    end
    return r;
  endfunction

  always @(posedge clk) begin
    m4 = step(m4, 4, rst_n, flush4, rdy4, 8'(req4));
    m6 = step(m6, 6, rst_n, flush6, rdy6, 8'(req6));
  end

  always @(negedge clk) begin
    if (checking) begin
      chk("u4_vld", 32'(vld4), 32'(m4.v));
      chk("u4_idx", 32'(idx4), m4.idx);
      chk("u4_oh",  32'(oh4), m4.v ? (32'd1 << m4.idx) : 32'd0);
      chk("u4_ptr", 32'(u4.ptr), m4.ptr);
      chk("u6_vld", 32'(vld6), 32'(m6.v));
      chk("u6_idx", 32'(idx6), m6.idx);
      chk("u6_oh",  32'(oh6), m6.v ? (32'd1 << m6.idx) : 32'd0);
      chk("u6_ptr", 32'(u6.ptr), m6.ptr);
      chk("u6_idx_range", 32'(idx6 < 3'd6), 32'd1);
      if (vld4) chk("u4_oh2bin", onehot_to_bin(32'(oh4)), 32'(idx4));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic d4(input logic [3:0] r, input logic rdy, input logic fl);
    req4 = r; rdy4 = rdy; flush4 = fl;
    tick();
  endtask

  task automatic d6(input logic [5:0] r, input logic rdy);
    req6 = r; rdy6 = rdy;
    tick();
  endtask

  initial begin
    int exp_seq[4] = '{1, 2, 3, 0};
    rst_n = 1'b0;
    req4 = '0; rdy4 = 1'b0; flush4 = 1'b0;
    req6 = '0; rdy6 = 1'b0; flush6 = 1'b0;
    tick();
    checking = 1'b1;
    tick();
    chk("rst_vld", 32'(vld4), 32'd0);
    chk("rst_oh", 32'(oh4), 32'd0);
    rst_n = 1'b1;

    // Reset arriving while a grant is stalled.
    d4(4'b0100, 1'b0, 1'b0);
    chk("stall_pre_idx", 32'(idx4), 32'd2);
    d4(4'b0100, 1'b0, 1'b0);
    rst_n = 1'b0;
    tick();
    chk("midrst_vld", 32'(vld4), 32'd0);
    chk("midrst_idx", 32'(idx4), 32'd0);
    chk("midrst_oh", 32'(oh4), 32'd0);
    rst_n = 1'b1;
    d4(4'b1111, 1'b1, 1'b0);
    chk("post_rst_idx", 32'(idx4), 32'd0);

    // All requesting with ready held high.
    for (int k = 0; k < 4; k++) begin
      d4(4'b1111, 1'b1, 1'b0);
      chk("sweep_vld", 32'(vld4), 32'd1);
      chk("sweep_idx", 32'(idx4), exp_seq[k]);
    end

    // Frozen output while stalled even as req changes.
    d4(4'b0000, 1'b1, 1'b0);
    chk("drain_vld", 32'(vld4), 32'd0);
    d4(4'b0100, 1'b1, 1'b0);
    chk("stall_idx0", 32'(idx4), 32'd2);
    for (int k = 0; k < 3; k++) begin
      d4(4'b0001, 1'b0, 1'b0);
      chk("stall_idx", 32'(idx4), 32'd2);
      chk("stall_oh", 32'(oh4), 32'h4);
    end
    d4(4'b0001, 1'b1, 1'b0);
    chk("unstall_idx", 32'(idx4), 32'd0);

    // Accepted requester drops to lowest priority.
    d4(4'b0010, 1'b1, 1'b0);
    chk("acc1_idx", 32'(idx4), 32'd1);
    d4(4'b0011, 1'b1, 1'b0);
    chk("prio_idx0", 32'(idx4), 32'd0);
    d4(4'b0011, 1'b1, 1'b0);
    chk("prio_idx1", 32'(idx4), 32'd1);

    // Flush of a pending idx-3 grant loaded with ptr at 0.
    d4(4'b1000, 1'b1, 1'b0);
    d4(4'b1000, 1'b1, 1'b0);
    chk("fl_pend_idx", 32'(idx4), 32'd3);
    d4(4'b1000, 1'b0, 1'b0);
    d4(4'b1000, 1'b0, 1'b1);
    chk("fl_vld", 32'(vld4), 32'd0);
    chk("fl_oh", 32'(oh4), 32'd0);
    chk("fl_ptr", 32'(u4.ptr), 32'd0);
    d4(4'b1001, 1'b1, 1'b0);
    chk("fl_after_idx", 32'(idx4), 32'd0);

    // N=6 wrap from 5 back to 0, then empty request with load enabled.
    d4(4'b0000, 1'b1, 1'b0);
    d6(6'b100000, 1'b1);
    chk("n6_idx5", 32'(idx6), 32'd5);
    d6(6'b100001, 1'b1);
    chk("n6_wrap_idx", 32'(idx6), 32'd0);
    d6(6'b000000, 1'b1);
    chk("n6_empty_vld", 32'(vld6), 32'd0);
    d6(6'b000000, 1'b1);
    chk("n6_empty_vld2", 32'(vld6), 32'd0);

    for (int c = 0; c < 1000; c++) begin
      rst_n  = ($urandom_range(0, 99) != 0);
      req4   = 4'($urandom);
      rdy4   = ($urandom_range(0, 3) != 0);
      flush4 = ($urandom_range(0, 15) == 0);
      req6   = ($urandom_range(0, 7) == 0) ? 6'd0 : 6'($urandom);
      rdy6   = ($urandom_range(0, 3) != 0);
      flush6 = ($urandom_range(0, 15) == 0);
      tick();
    end

    @(negedge clk);
    checking = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
